// File: rtl/cache_pkg.sv
// Shared types and helpers for the write-back direct-mapped cache controller.
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOOKUP  = 3'd1,
    WB      = 3'd2,
    RF      = 3'd3,
    RESP    = 3'd4,
    FL_SCAN = 3'd5,
    FL_WB   = 3'd6
  } state_t;

  function automatic int off_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int tag_w(input int addr_w, input int index_w, input int line_words);
    return addr_w - index_w - $clog2(line_words);
  endfunction

  // Extracts a field of 'width' bits starting at 'lsb' from a zero-extended address.
  function automatic logic [31:0] addr_field(input logic [31:0] addr, input int lsb, input int width);
    logic [31:0] mask;
    mask = (32'd1 << width) - 32'd1;
    return (addr >> lsb) & mask;
  endfunction

endpackage

// File: rtl/wb_cache_ctrl_if.sv
// CPU request port and main-memory beat port of the cache controller.
interface wb_cache_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ready;
  logic              cpu_hit;
  logic [DATA_W-1:0] cpu_rdata;
  logic              flush;
  logic              flush_done;
  logic              busy;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic              mem_done;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, flush, mem_ready, mem_done, mem_rdata,
    output cpu_ready, cpu_hit, cpu_rdata, flush_done, busy, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, flush, mem_ready, mem_done, mem_rdata,
    input  cpu_ready, cpu_hit, cpu_rdata, flush_done, busy, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_line_store.sv
// Tag/valid/dirty and data storage for a direct-mapped cache; all ports act on one index.
module cache_line_store
  import cache_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int INDEX_W    = 5,
  parameter int LINE_WORDS = 8,
  parameter int TAG_W      = 8,
  parameter int OFF_W      = off_w(LINE_WORDS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] index,
  input  logic [OFF_W-1:0]   word,
  output logic               rd_valid,
  output logic               rd_dirty,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [DATA_W-1:0]  rd_data,
  input  logic               wr_en,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic               fill_en,
  input  logic [TAG_W-1:0]   fill_tag,
  input  logic               dirty_set,
  input  logic               inval
);
  localparam int LINES = 32'd1 << INDEX_W;

  logic [LINES-1:0]   valid_q, valid_d;
  logic [LINES-1:0]   dirty_q, dirty_d;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [DATA_W-1:0]  data_q [LINES*LINE_WORDS];
  logic [INDEX_W+OFF_W-1:0] word_addr;

  assign word_addr = {index, word};
  assign rd_valid  = valid_q[index];
  assign rd_dirty  = dirty_q[index];
  assign rd_tag    = tag_q[index];
  assign rd_data   = data_q[word_addr];

  // Next valid/dirty state; invalidate wins over fill, fill wins over dirty marking.
  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (inval) begin
      valid_d[index] = 1'b0;
      dirty_d[index] = 1'b0;
    end else if (fill_en) begin
      valid_d[index] = 1'b1;
      dirty_d[index] = 1'b0;
    end else if (dirty_set) begin
      dirty_d[index] = 1'b1;
    end else begin
      valid_d = valid_q;
      dirty_d = dirty_q;
    end
  end

  // Line state registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tag and data arrays need no reset: valid gates every use.
  always_ff @(posedge clk) begin
    if (wr_en) data_q[word_addr] <= wr_data;
    if (fill_en) tag_q[index] <= fill_tag;
  end
endmodule

// File: rtl/wb_cache_ctrl.sv
// Direct-mapped write-back/write-allocate cache controller with whole-cache flush.
module wb_cache_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int INDEX_W    = 5,
  parameter int LINE_WORDS = 8
) (
  input  logic            clk,
  input  logic            rst,
  wb_cache_ctrl_if.slave  bus
);
  localparam int OFF_W = off_w(LINE_WORDS);
  localparam int TAG_W = tag_w(ADDR_W, INDEX_W, LINE_WORDS);
  localparam logic [OFF_W-1:0]   LAST_BEAT  = OFF_W'(LINE_WORDS - 1);
  localparam logic [OFF_W-1:0]   BEAT_ONE   = OFF_W'(1);
  localparam logic [INDEX_W-1:0] LAST_INDEX = '1;
  localparam logic [INDEX_W-1:0] INDEX_ONE  = INDEX_W'(1);

  state_t state_q, state_d;
  logic [OFF_W-1:0]   beat_q, beat_d;
  logic [INDEX_W-1:0] fl_idx_q, fl_idx_d;
  logic               pend_q, pend_d;
  logic               req_we_q, req_we_d;
  logic [ADDR_W-1:0]  req_addr_q, req_addr_d;
  logic [DATA_W-1:0]  req_wdata_q, req_wdata_d;
  logic               cpu_ready_q, cpu_ready_d, cpu_hit_q, cpu_hit_d;
  logic [DATA_W-1:0]  cpu_rdata_q, cpu_rdata_d;
  logic               flush_done_q, flush_done_d, busy_q, busy_d;
  logic               mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;

  logic [TAG_W-1:0]   req_tag, st_tag, st_fill_tag;
  logic [INDEX_W-1:0] req_index, st_index;
  logic [OFF_W-1:0]   req_off, st_word;
  logic               st_valid, st_dirty, st_wr_en, st_fill, st_dirty_set, st_inval;
  logic [DATA_W-1:0]  st_rdata, st_wr_data;
  logic               flushing;

  assign req_tag     = TAG_W'(addr_field(32'(req_addr_q), INDEX_W + OFF_W, TAG_W));
  assign req_index   = INDEX_W'(addr_field(32'(req_addr_q), OFF_W, INDEX_W));
  assign req_off     = OFF_W'(addr_field(32'(req_addr_q), 0, OFF_W));
  assign flushing    = (state_q == FL_SCAN) || (state_q == FL_WB);
  assign st_index    = flushing ? fl_idx_q : req_index;
  assign st_fill_tag = req_tag;

  cache_line_store #(
    .DATA_W(DATA_W), .INDEX_W(INDEX_W), .LINE_WORDS(LINE_WORDS), .TAG_W(TAG_W)
  ) u_store (
    .clk(clk), .rst(rst), .index(st_index), .word(st_word),
    .rd_valid(st_valid), .rd_dirty(st_dirty), .rd_tag(st_tag), .rd_data(st_rdata),
    .wr_en(st_wr_en), .wr_data(st_wr_data), .fill_en(st_fill), .fill_tag(st_fill_tag),
    .dirty_set(st_dirty_set), .inval(st_inval)
  );

  // Next-state, beat sequencing, store controls and next values of registered outputs.
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    fl_idx_d     = fl_idx_q;
    pend_d       = pend_q;
    req_we_d     = req_we_q;
    req_addr_d   = req_addr_q;
    req_wdata_d  = req_wdata_q;
    cpu_ready_d  = 1'b0;
    cpu_hit_d    = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    flush_done_d = 1'b0;
    mem_req_d    = 1'b0;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    st_word      = req_off;
    st_wr_en     = 1'b0;
    st_wr_data   = req_wdata_q;
    st_fill      = 1'b0;
    st_dirty_set = 1'b0;
    st_inval     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.flush) begin
          fl_idx_d = '0;
          state_d  = FL_SCAN;
        end else if (bus.cpu_req && !cpu_ready_q) begin
          req_we_d    = bus.cpu_we;
          req_addr_d  = bus.cpu_addr;
          req_wdata_d = bus.cpu_wdata;
          state_d     = LOOKUP;
        end else begin
          state_d = IDLE;
        end
      end
      LOOKUP: begin
        if (st_valid && (st_tag == req_tag)) begin
          cpu_ready_d  = 1'b1;
          cpu_hit_d    = 1'b1;
          cpu_rdata_d  = req_we_q ? cpu_rdata_q : st_rdata;
          st_wr_en     = req_we_q;
          st_dirty_set = req_we_q;
          state_d      = IDLE;
        end else begin
          beat_d  = '0;
          state_d = (st_valid && st_dirty) ? WB : RF;
        end
      end
      // Eviction beats: the old tag is still in the store until the refill completes.
      WB, FL_WB: begin
        st_word = beat_q;
        if (!pend_q) begin
          if (bus.mem_ready) begin
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = {st_tag, st_index, beat_q};
            mem_wdata_d = st_rdata;
            pend_d      = 1'b1;
          end else begin
            pend_d = 1'b0;
          end
        end else if (bus.mem_done) begin
          pend_d = 1'b0;
          beat_d = beat_q + BEAT_ONE;
          if (beat_q == LAST_BEAT) begin
            st_inval = (state_q == FL_WB);
            state_d  = (state_q == FL_WB) ? FL_SCAN : RF;
          end else begin
            state_d = state_q;
          end
        end else begin
          pend_d = 1'b1;
        end
      end
      RF: begin
        st_word    = beat_q;
        st_wr_data = bus.mem_rdata;
        if (!pend_q) begin
          if (bus.mem_ready) begin
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = {req_tag, req_index, beat_q};
            pend_d     = 1'b1;
          end else begin
            pend_d = 1'b0;
          end
        end else if (bus.mem_done) begin
          st_wr_en = 1'b1;
          pend_d   = 1'b0;
          beat_d   = beat_q + BEAT_ONE;
          if (beat_q == LAST_BEAT) begin
            st_fill = 1'b1;
            state_d = RESP;
          end else begin
            state_d = RF;
          end
        end else begin
          pend_d = 1'b1;
        end
      end
      RESP: begin
        cpu_ready_d = 1'b1;
        if (req_we_q) begin
          st_wr_en     = 1'b1;
          st_dirty_set = 1'b1;
        end else begin
          cpu_rdata_d = st_rdata;
        end
        state_d = IDLE;
      end
      FL_SCAN: begin
        if (st_valid && st_dirty) begin
          beat_d  = '0;
          state_d = FL_WB;
        end else begin
          st_inval = 1'b1;
          if (fl_idx_q == LAST_INDEX) begin
            flush_done_d = 1'b1;
            state_d      = IDLE;
          end else begin
            fl_idx_d = fl_idx_q + INDEX_ONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Controller state and registered outputs; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      fl_idx_q     <= '0;
      pend_q       <= 1'b0;
      req_we_q     <= 1'b0;
      req_addr_q   <= '0;
      req_wdata_q  <= '0;
      cpu_ready_q  <= 1'b0;
      cpu_hit_q    <= 1'b0;
      cpu_rdata_q  <= '0;
      flush_done_q <= 1'b0;
      busy_q       <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      fl_idx_q     <= fl_idx_d;
      pend_q       <= pend_d;
      req_we_q     <= req_we_d;
      req_addr_q   <= req_addr_d;
      req_wdata_q  <= req_wdata_d;
      cpu_ready_q  <= cpu_ready_d;
      cpu_hit_q    <= cpu_hit_d;
      cpu_rdata_q  <= cpu_rdata_d;
      flush_done_q <= flush_done_d;
      busy_q       <= busy_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign bus.cpu_ready  = cpu_ready_q;
  assign bus.cpu_hit    = cpu_hit_q;
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.flush_done = flush_done_q;
  assign bus.busy       = busy_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
endmodule

// File: tb/tb_wb_cache_ctrl.sv
// Directed bench for wb_cache_ctrl with a 3-cycle memory where untouched mem[a] = 0xA0000000 | a.
module tb_wb_cache_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_cache_ctrl_if #(.ADDR_W(16), .DATA_W(32)) bus ();
  wb_cache_ctrl #(.ADDR_W(16), .DATA_W(32), .INDEX_W(5), .LINE_WORDS(8)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Memory model state and beat logs
  logic [31:0] wmem [0:65535];
  logic [65535:0] wset = '0;
  int mcnt = 0, rcnt = 0, wcnt = 0, req_cnt = 0, proto_bad = 0;
  logic m_we = 1'b0;
  logic [15:0] m_addr = 16'h0000;
  logic [31:0] m_wdata = 32'h0;
  logic [15:0] rlog [0:511];
  logic [15:0] wlog_a [0:511];
  logic [31:0] wlog_d [0:511];

  function automatic logic [31:0] mem_val(input logic [15:0] a);
    return wset[a] ? wmem[a] : (32'hA000_0000 | {16'h0000, a});
  endfunction

  assign bus.mem_ready = (mcnt == 0);

  // Single-outstanding memory: done three edges after the request is taken
  always @(posedge clk) begin
    bus.mem_done <= 1'b0;
    if (bus.mem_req && !bus.mem_ready) proto_bad <= proto_bad + 1;
    if (bus.mem_req) req_cnt <= req_cnt + 1;
    if (bus.mem_req && mcnt == 0) begin
      m_we    <= bus.mem_we;
      m_addr  <= bus.mem_addr;
      m_wdata <= bus.mem_wdata;
      mcnt    <= 3;
      if (bus.mem_we) begin
        wlog_a[wcnt & 511] <= bus.mem_addr;
        wlog_d[wcnt & 511] <= bus.mem_wdata;
        wcnt <= wcnt + 1;
      end else begin
        rlog[rcnt & 511] <= bus.mem_addr;
        rcnt <= rcnt + 1;
      end
    end else if (mcnt != 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) begin
        bus.mem_done  <= 1'b1;
        bus.mem_rdata <= mem_val(m_addr);
        if (m_we) begin
          wmem[m_addr]   <= m_wdata;
          wset[m_addr]   <= 1'b1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One CPU access from IDLE; cyc counts negedges after the acceptance edge until cpu_ready.
  task automatic cpu_access(input logic we, input logic [15:0] addr, input logic [31:0] wd,
                            output logic hit, output logic [31:0] rd, output int cyc);
    @(posedge clk); #1;
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wd;
    @(posedge clk);
    cyc = 0; hit = 1'b0; rd = 32'h0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      cyc++;
      if (bus.cpu_ready) begin
        hit = bus.cpu_hit;
        rd  = bus.cpu_rdata;
        break;
      end
    end
    chk("cpu_ready_seen", {63'd0, bus.cpu_ready}, 64'd1);
    bus.cpu_req = 1'b0;
  endtask

  logic        hit;
  logic [31:0] rd;
  int cyc, r0, w0, q0, busy_low;
  logic done_seen;

  initial begin
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0; bus.cpu_wdata = 32'h0;
    bus.flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {63'd0, bus.cpu_ready}, 64'd0);
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_mem_req", {63'd0, bus.mem_req}, 64'd0);
    chk("rst_flush_done", {63'd0, bus.flush_done}, 64'd0);
    rst = 1'b0;

    // 1: cold read then hit
    r0 = rcnt; w0 = wcnt;
    cpu_access(1'b0, 16'h0123, 32'h0, hit, rd, cyc);
    chk("t1_hit", {63'd0, hit}, 64'd0);
    chk("t1_rdata", 64'(rd), 64'hA000_0123);
    chk("t1_rbeats", 64'(rcnt - r0), 64'd8);
    chk("t1_wbeats", 64'(wcnt - w0), 64'd0);
    for (int i = 0; i < 8; i++) chk("t1_raddr", 64'(rlog[(r0 + i) & 511]), 64'(16'h0120 + i));
    q0 = req_cnt;
    cpu_access(1'b0, 16'h0123, 32'h0, hit, rd, cyc);
    chk("t1_rehit", {63'd0, hit}, 64'd1);
    chk("t1_rerdata", 64'(rd), 64'hA000_0123);
    chk("t1_hit_lat", 64'(cyc), 64'd2);
    chk("t1_hit_noreq", 64'(req_cnt - q0), 64'd0);

    // 2: write hit then read back
    q0 = req_cnt;
    cpu_access(1'b1, 16'h0124, 32'hDEAD_BEEF, hit, rd, cyc);
    chk("t2_whit", {63'd0, hit}, 64'd1);
    cpu_access(1'b0, 16'h0124, 32'h0, hit, rd, cyc);
    chk("t2_rhit", {63'd0, hit}, 64'd1);
    chk("t2_rdata", 64'(rd), 64'hDEAD_BEEF);
    chk("t2_noreq", 64'(req_cnt - q0), 64'd0);

    // 3: dirty miss on index 4
    r0 = rcnt; w0 = wcnt;
    cpu_access(1'b0, 16'h2123, 32'h0, hit, rd, cyc);
    chk("t3_hit", {63'd0, hit}, 64'd0);
    chk("t3_rdata", 64'(rd), 64'hA000_2123);
    chk("t3_wbeats", 64'(wcnt - w0), 64'd8);
    chk("t3_rbeats", 64'(rcnt - r0), 64'd8);
    for (int i = 0; i < 8; i++) begin
      chk("t3_waddr", 64'(wlog_a[(w0 + i) & 511]), 64'(16'h0120 + i));
      chk("t3_raddr", 64'(rlog[(r0 + i) & 511]), 64'(16'h2120 + i));
    end
    chk("t3_wdata4", 64'(wlog_d[(w0 + 4) & 511]), 64'hDEAD_BEEF);
    chk("t3_wdata0", 64'(wlog_d[w0 & 511]), 64'hA000_0120);

    // 4: write miss on a clean index
    r0 = rcnt; w0 = wcnt;
    cpu_access(1'b1, 16'h0456, 32'h1234_5678, hit, rd, cyc);
    chk("t4_hit", {63'd0, hit}, 64'd0);
    chk("t4_rbeats", 64'(rcnt - r0), 64'd8);
    chk("t4_wbeats", 64'(wcnt - w0), 64'd0);
    chk("t4_raddr0", 64'(rlog[r0 & 511]), 64'h0450);
    chk("t4_mem_kept", 64'(mem_val(16'h0456)), 64'hA000_0456);
    cpu_access(1'b0, 16'h0456, 32'h0, hit, rd, cyc);
    chk("t4_rhit", {63'd0, hit}, 64'd1);
    chk("t4_rdata", 64'(rd), 64'h1234_5678);

    // 5: make 0x0124 dirty again, then flush
    w0 = wcnt;
    cpu_access(1'b1, 16'h0124, 32'hCAFE_F00D, hit, rd, cyc);
    chk("t5_wmiss", {63'd0, hit}, 64'd0);
    chk("t5_clean_evict", 64'(wcnt - w0), 64'd0);
    w0 = wcnt;
    @(posedge clk); #1 bus.flush = 1'b1;
    @(posedge clk); #1 bus.flush = 1'b0;
    busy_low = 0; done_seen = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (bus.flush_done) begin
        done_seen = 1'b1;
        break;
      end
      if (!bus.busy) busy_low++;
    end
    chk("t5_done", {63'd0, done_seen}, 64'd1);
    chk("t5_busy_low", 64'(busy_low), 64'd0);
    chk("t5_wbeats", 64'(wcnt - w0), 64'd16);
    chk("t5_waddr0", 64'(wlog_a[w0 & 511]), 64'h0120);
    chk("t5_wdata3", 64'(wlog_d[(w0 + 3) & 511]), 64'hA000_0123);
    chk("t5_wdata4", 64'(wlog_d[(w0 + 4) & 511]), 64'hCAFE_F00D);
    chk("t5_waddr8", 64'(wlog_a[(w0 + 8) & 511]), 64'h0450);
    chk("t5_wdata14", 64'(wlog_d[(w0 + 14) & 511]), 64'h1234_5678);
    @(negedge clk);
    chk("t5_done_pulse", {63'd0, bus.flush_done}, 64'd0);
    chk("t5_idle", {63'd0, bus.busy}, 64'd0);
    cpu_access(1'b0, 16'h0456, 32'h0, hit, rd, cyc);
    chk("t5_postflush_hit", {63'd0, hit}, 64'd0);
    chk("t5_postflush_rdata", 64'(rd), 64'h1234_5678);

    // 6: reset during refill beat 3
    r0 = rcnt;
    @(posedge clk); #1;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0777;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (rcnt - r0 >= 4) break;
    end
    chk("t6_reached_beat3", 64'(rcnt - r0), 64'd4);
    rst = 1'b1;
    #1;
    chk("t6_mem_req", {63'd0, bus.mem_req}, 64'd0);
    chk("t6_busy", {63'd0, bus.busy}, 64'd0);
    chk("t6_ready", {63'd0, bus.cpu_ready}, 64'd0);
    chk("t6_mem_addr", 64'(bus.mem_addr), 64'd0);
    chk("t6_rdata", 64'(bus.cpu_rdata), 64'd0);
    bus.cpu_req = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst = 1'b0;
    r0 = rcnt;
    cpu_access(1'b0, 16'h0777, 32'h0, hit, rd, cyc);
    chk("t6_hit", {63'd0, hit}, 64'd0);
    chk("t6_rbeats", 64'(rcnt - r0), 64'd8);
    chk("t6_raddr0", 64'(rlog[r0 & 511]), 64'h0770);
    chk("t6_rdata_after", 64'(rd), 64'hA000_0777);

    chk("mem_protocol", 64'(proto_bad), 64'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/wb_cache_ctrl.md
Name: wb_cache_ctrl

Overview:
Parametrised direct-mapped cache controller with a write-back, write-allocate policy. It replaces the write-through/no-allocate memory-system top. It sits between the CPU request port and the main-memory handshake port, which is external to the block so memory latency is set by the bench. Each line carries a dirty bit; dirty lines are evicted before refill, and a flush command writes back and invalidates the whole cache.

Parameters:
ADDR_W, 16, word address width
DATA_W, 32, data word width
INDEX_W, 5, index bits; number of lines is 2^INDEX_W
LINE_WORDS, 8, words per line; power of two, at least 2; OFF_W = log2(LINE_WORDS), TAG_W = ADDR_W-INDEX_W-OFF_W

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
cpu_req  in  1  request; held with we/addr/wdata until cpu_ready
cpu_we  in  1  1 = write
cpu_addr  in  ADDR_W  word address
cpu_wdata  in  DATA_W  write data
cpu_ready  out  1  one-cycle completion pulse
cpu_hit  out  1  valid with cpu_ready; 1 = hit
cpu_rdata  out  DATA_W  read data, valid with cpu_ready
flush  in  1  pulse: write back all dirty lines, then invalidate all lines
flush_done  out  1  one-cycle pulse at flush completion
busy  out  1  high whenever state is not IDLE
mem_req  out  1  one-cycle request pulse
mem_we  out  1  1 = write beat
mem_addr  out  ADDR_W  beat address
mem_wdata  out  DATA_W  write-beat data
mem_ready  in  1  memory can accept a request
mem_done  in  1  one-cycle pulse: beat complete; mem_rdata valid for reads

Behaviour:
- Address split: tag = addr[ADDR_W-1 -: TAG_W], index = next INDEX_W bits, offset = low OFF_W bits.
- Reset: all outputs 0; all valid and dirty bits cleared; state IDLE; beat counter 0. Reset mid-operation aborts the transaction, and nothing is replayed.
- All CPU and memory outputs are registered.
- Acceptance: in IDLE, flush has priority over cpu_req. cpu_req is accepted only when cpu_ready = 0, which prevents re-acceptance in the response cycle. Accepted address and data are latched.
- States:
  - IDLE: on flush go to FL_SCAN; on cpu_req go to LOOKUP.
  - LOOKUP: hit = valid and tag match.
    - Read hit: cpu_ready=1, cpu_hit=1, cpu_rdata = line word, then IDLE.
    - Write hit: write the word, set dirty, cpu_ready=1, cpu_hit=1, then IDLE.
    - Miss on a valid dirty line: go to WB. Otherwise go to RF.
  - WB: for beats 0..LINE_WORDS-1, when mem_ready issue mem_req with mem_we=1, mem_addr = {old_tag, index, beat}, mem_wdata = stored word. Wait for mem_done before the next beat. After the last done, go to RF.
  - RF: same beat scheme with mem_we=0 and mem_addr = {req_tag, index, beat}. Each mem_done writes mem_rdata into word[beat]. After the last done, write the tag, set valid, clear dirty, and go to RESP.
  - RESP: cpu_ready=1, cpu_hit=0.
    - Read: cpu_rdata = word[offset].
    - Write: merge cpu_wdata into word[offset] and set dirty.
    - Then IDLE.
  - FL_SCAN / FL_WB: walk index 0..2^INDEX_W-1. Write back each dirty valid line using the WB beat scheme. Clear valid and dirty on every line. After the last index, pulse flush_done and return to IDLE.
- Memory rules: at most one outstanding beat. mem_req is asserted only when mem_ready=1. A mem_done that arrives while no beat is outstanding is ignored.
- Latency: a read hit gives cpu_ready 2 cycles after the acceptance edge. A clean miss adds LINE_WORDS memory beats. A dirty miss adds 2*LINE_WORDS memory beats.
- Beat counter is OFF_W wide and wraps to 0 after the last beat.
- cpu_req and flush arriving while busy: flush is ignored while busy; cpu_req waits until IDLE.

Decomposition:
- Package cache_pkg: state enum; functions for TAG_W/OFF_W derivation; address-field extract helpers.
- Sub-module cache_line_store holds the valid/dirty/tag arrays and the data array. It has:
  - combinational read by index and word;
  - a word write port;
  - tag/valid/dirty set-clear ports;
  - an invalidate-by-index port;
  - asynchronous reset of valid and dirty.
- The wb_cache_ctrl top holds the FSM, beat counter, request latches and registered outputs.

Test Plan:
All scenarios use the defaults and a memory model with 3-cycle latency where mem[a] = 0xA0000000 | a.
1. Cold read of 0x0123 -> 8 read beats at 0x0120..0x0127, then cpu_ready with hit=0 and rdata=0xA0000123. Re-reading 0x0123 -> hit=1 two cycles after acceptance, with no mem_req.
2. Write of 0x0124 = 0xDEADBEEF (line resident) -> hit=1 and no memory traffic. A read of 0x0124 then returns 0xDEADBEEF.
3. Read of 0x2123 (index 4, tag 0x21) -> 8 write beats at 0x0120..0x0127, including 0xDEADBEEF at 0x0124. Then 8 read beats from 0x2120, and rdata=0xA0002123.
4. Write miss at 0x0456 = 0x12345678 on a clean index -> refill 0x0450..0x0457 with no write beats, hit=0. mem[0x0456] stays unchanged. A read of 0x0456 then gives hit=1 and 0x12345678.
5. Two dirty lines (0x0456 and 0x0124), then a flush pulse -> exactly 16 write beats, busy high throughout, then a flush_done pulse. The next read of 0x0456 misses.
6. rst asserted during refill beat 3 -> mem_req and all outputs at 0 immediately, busy=0. A following read of the same address misses and refills all 8 beats.
